// File: rtl/mult16s_dot_accumulator_if.sv
// Product-in / group-sum-out bus between the multiplier stage and the dot accumulator.
// Latency: n/a (signal bundle only).
// Backpressure: in_valid/in_ready on the product side, out_valid/out_ready on the sum side.
interface mult16s_dot_accumulator_if #(
  parameter int PROD_W = 32,
  parameter int ACC_W  = 40
);
  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_product;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic              out_overflow;
  logic [15:0]       group_cnt;

  // Accumulator side: consumes products, produces group sums.
  modport slave (
    input  in_valid, in_product, out_ready,
    output in_ready, out_valid, out_sum, out_overflow, group_cnt
  );

  // Producer/consumer side: drives products and takes group sums.
  modport master (
    output in_valid, in_product, out_ready,
    input  in_ready, out_valid, out_sum, out_overflow, group_cnt
  );
endinterface

// File: rtl/mult16s_dot_accumulator.sv
// Sums groups of LEN signed products into an ACC_W-bit result with a sticky per-group overflow flag.
// Latency: out_valid rises one cycle after the accept of a group's last product.
// Backpressure: in_ready = ~(out_valid & ~out_ready); the input stalls only while a finished sum is held.
// Optional: define MULT16S_DOT_ACC_SAT_EN for saturating accumulation (default build wraps).
module mult16s_dot_accumulator #(
  parameter int PROD_W = 32,
  parameter int ACC_W  = 40,
  parameter int LEN    = 16
) (
  input logic                      clk,
  input logic                      rst,
  mult16s_dot_accumulator_if.slave bus
);

  logic             w_in_ready;
  logic             w_accept;
  logic             w_first;
  logic             w_last;
  logic [ACC_W-1:0] w_prod_ext;
  logic [ACC_W-1:0] w_base;
  logic [ACC_W-1:0] w_raw;
  logic [ACC_W-1:0] w_step;
  logic             w_step_ovf;
  logic             w_grp_ovf;

  logic [ACC_W-1:0] r_acc;
  logic [15:0]      r_cnt;
  logic             r_ovf;
  logic             r_out_valid;
  logic [ACC_W-1:0] r_out_sum;
  logic             r_out_ovf;

  // Stall only while a finished sum is held and the consumer is not taking it.
  assign w_in_ready = ~(r_out_valid & ~bus.out_ready);
  assign w_accept   = bus.in_valid & w_in_ready;

  // For LEN=1 the first product is also the last, so the sum is just the product.
  assign w_first = (r_cnt == 16'd0);
  assign w_last  = (r_cnt == 16'(LEN-1));

  // The first product of a group replaces whatever the accumulator held.
  assign w_prod_ext = {{(ACC_W-PROD_W){bus.in_product[PROD_W-1]}}, bus.in_product};
  assign w_base     = w_first ? '0 : r_acc;
  assign w_raw      = w_base + w_prod_ext;

  // Signed overflow: addends share a sign and the result does not.
  assign w_step_ovf = (w_base[ACC_W-1] == w_prod_ext[ACC_W-1]) &&
                      (w_raw[ACC_W-1] != w_base[ACC_W-1]);
  assign w_grp_ovf  = (~w_first & r_ovf) | w_step_ovf;

`ifdef MULT16S_DOT_ACC_SAT_EN
  localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  // On overflow both addends share a sign, which picks the rail to clamp to.
  assign w_step = w_step_ovf ? (w_base[ACC_W-1] ? SAT_MIN : SAT_MAX) : w_raw;
`else
  assign w_step = w_raw;
`endif

  // Partial-sum state: accumulate on every accept except the group's last.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (w_accept) begin
      if (w_last) begin
        r_cnt <= '0;
      end else begin
        r_acc <= w_step;
        r_ovf <= w_grp_ovf;
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end

  // Output register: load on group completion, which also wins over a drain in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_ovf   <= 1'b0;
    end else if (w_accept && w_last) begin
      r_out_valid <= 1'b1;
      r_out_sum   <= w_step;
      r_out_ovf   <= w_grp_ovf;
    end else if (r_out_valid && bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready     = w_in_ready;
  assign bus.out_valid    = r_out_valid;
  assign bus.out_sum      = r_out_sum;
  assign bus.out_overflow = r_out_ovf;
  assign bus.group_cnt    = r_cnt;

endmodule

// File: tb/tb_mult16s_dot_accumulator.sv
// Scoreboard bench for mult16s_dot_accumulator across four LEN/ACC_W configurations.
// Directed groups from the block's intended use, then randomized products and out_ready.
// Expected sums come from exact integer arithmetic with range-based wrap/saturation.
module tb_mult16s_dot_accumulator;

  localparam int NI = 4;

  function automatic int len_of(input int i);
    case (i)
      0:       return 2;
      1:       return 4;
      2:       return 4;
      default: return 1;
    endcase
  endfunction

  function automatic int accw_of(input int i);
    case (i)
      0:       return 40;
      1:       return 40;
      default: return 33;
    endcase
  endfunction

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid   [NI];
  logic [31:0] in_product [NI];
  logic        out_ready  [NI];
  logic        in_ready_w [NI];
  logic        out_valid_w[NI];
  logic        out_ovf_w  [NI];
  logic [39:0] out_sum_w  [NI];
  logic [15:0] gcnt_w     [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int L = len_of(g);
    localparam int W = accw_of(g);
    mult16s_dot_accumulator_if #(.PROD_W(32), .ACC_W(W)) bus ();
    assign bus.in_valid   = in_valid[g];
    assign bus.in_product = in_product[g];
    assign bus.out_ready  = out_ready[g];
    assign in_ready_w[g]  = bus.in_ready;
    assign out_valid_w[g] = bus.out_valid;
    assign out_ovf_w[g]   = bus.out_overflow;
    assign out_sum_w[g]   = 40'($signed(bus.out_sum));
    assign gcnt_w[g]      = bus.group_cnt;
    mult16s_dot_accumulator #(.PROD_W(32), .ACC_W(W), .LEN(L)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [39:0] sum;
    logic        ovf;
  } exp_t;

  exp_t q0[$], q1[$], q2[$], q3[$];

  function automatic int qsize(input int i);
    case (i)
      0:       return q0.size();
      1:       return q1.size();
      2:       return q2.size();
      default: return q3.size();
    endcase
  endfunction

  function automatic exp_t qfront(input int i);
    case (i)
      0:       return q0[0];
      1:       return q1[0];
      2:       return q2[0];
      default: return q3[0];
    endcase
  endfunction

  function automatic void qpop(input int i);
    case (i)
      0:       q0.delete(0);
      1:       q1.delete(0);
      2:       q2.delete(0);
      default: q3.delete(0);
    endcase
  endfunction

  function automatic void qpush(input int i, input exp_t e);
    case (i)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      2:       q2.push_back(e);
      default: q3.push_back(e);
    endcase
  endfunction

  function automatic void qclear(input int i);
    case (i)
      0:       q0.delete();
      1:       q1.delete();
      2:       q2.delete();
      default: q3.delete();
    endcase
  endfunction

  // Exact sum, then folded back into the signed w-bit range (wrap or clamp).
  function automatic longint model_add(input longint part, input longint p, input int w,
                                       output bit ovf);
    longint mx;
    longint mn;
    longint s;
    mx  = (longint'(1) << (w-1)) - 1;
    mn  = -(longint'(1) << (w-1));
    s   = part + p;
    ovf = 1'b0;
    if (s > mx || s < mn) begin
      ovf = 1'b1;
`ifdef MULT16S_DOT_ACC_SAT_EN
      s = (s > mx) ? mx : mn;
`else
      if (s > mx) s = s - (longint'(1) << w);
      else        s = s + (longint'(1) << w);
`endif
    end
    return s;
  endfunction

  int     total = 0;
  int     bad   = 0;
  int     cycles = 0;
  int     drv_to = 0;
  bit     done  = 1'b0;
  longint m_part[NI];
  int     m_cnt [NI];
  bit     m_ovf [NI];
  bit     due   [NI];

  function automatic void chk(input string name, input int i,
                              input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s inst%0d: got %0h, expected %0h (t=%0t)", name, i, act, req, $time);
    end
  endfunction

  // Monitor: everything is stable at the falling edge, so both the output
  // handshake and any accept happening at the next rising edge are visible here.
  always @(negedge clk) begin
    cycles++;
    if (cycles > 40000) begin
      total++;
      bad++;
      $display("FAIL watchdog: cycles=%0d, expected completion before 40000", cycles);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        chk("rst_out_valid", i, 64'(out_valid_w[i]), 64'(1'b0));
        chk("rst_out_sum",   i, 64'(out_sum_w[i]),   64'(40'd0));
        chk("rst_out_ovf",   i, 64'(out_ovf_w[i]),   64'(1'b0));
        chk("rst_group_cnt", i, 64'(gcnt_w[i]),      64'(16'd0));
        m_part[i] = 0;
        m_cnt[i]  = 0;
        m_ovf[i]  = 1'b0;
        due[i]    = 1'b0;
        qclear(i);
      end else begin
        chk("in_ready", i, 64'(in_ready_w[i]), 64'(!(out_valid_w[i] && !out_ready[i])));
        chk("group_cnt", i, 64'(gcnt_w[i]), 64'(m_cnt[i]));
        if (due[i]) begin
          chk("latency_valid", i, 64'(out_valid_w[i]), 64'(1'b1));
          due[i] = 1'b0;
        end
        if (out_valid_w[i]) begin
          chk("result_expected", i, 64'(qsize(i) != 0), 64'(1'b1));
          if (qsize(i) != 0) begin
            exp_t e;
            e = qfront(i);
            chk("out_sum",      i, 64'(out_sum_w[i]), 64'(e.sum));
            chk("out_overflow", i, 64'(out_ovf_w[i]), 64'(e.ovf));
            if (out_ready[i]) qpop(i);
          end
        end
        if (in_valid[i] && in_ready_w[i]) begin
          bit   so;
          exp_t ne;
          if (m_cnt[i] == 0) begin
            m_part[i] = 0;
            m_ovf[i]  = 1'b0;
          end
          m_part[i] = model_add(m_part[i], longint'($signed(in_product[i])), accw_of(i), so);
          m_ovf[i]  = m_ovf[i] | so;
          m_cnt[i]++;
          if (m_cnt[i] == len_of(i)) begin
            ne.sum = 40'(m_part[i]);
            ne.ovf = m_ovf[i];
            qpush(i, ne);
            m_cnt[i] = 0;
            due[i]   = 1'b1;
          end
        end
      end
    end
    if (done) begin
      for (int i = 0; i < NI; i++) chk("drained", i, 64'(qsize(i)), 64'(0));
      chk("driver_timeouts", 0, 64'(drv_to), 64'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  // ---------------- stimulus ----------------
  // Called aligned just after a rising edge; returns just after the accepting edge.
  task automatic send(input int i, input logic [31:0] p, input bit rnd_rdy);
    int n;
    n = 0;
    in_valid[i]   = 1'b1;
    in_product[i] = p;
    while (1) begin
      @(negedge clk);
      if (in_ready_w[i]) break;
      n++;
      if (n > 200) begin
        drv_to++;
        break;
      end
      @(posedge clk);
      #1;
      if (rnd_rdy) out_ready[i] = 1'($urandom_range(0, 1));
    end
    @(posedge clk);
    #1;
    if (rnd_rdy) out_ready[i] = ($urandom_range(0, 3) != 0);
  endtask

  task automatic idle(input int i, input int n);
    in_valid[i]   = 1'b0;
    in_product[i] = $urandom;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send4(input int i, input logic [31:0] p);
    for (int k = 0; k < 4; k++) send(i, p, 1'b0);
    idle(i, 3);
  endtask

  initial begin
    int prev;
    int i;
    logic [31:0] p;
    logic [31:0] vals[8];
    rst = 1'b1;
    for (int k = 0; k < NI; k++) begin
      in_valid[k]   = 1'b0;
      in_product[k] = 32'd0;
      out_ready[k]  = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle(0, 1);

    // LEN=4, 1+2+3+4
    for (int k = 1; k <= 4; k++) send(1, 32'(k), 1'b0);
    idle(1, 3);
    // LEN=4, ACC_W=40: four 2^30 products fit without overflow
    send4(1, 32'h4000_0000);

    // LEN=2 stream: 2, 14, -10, 2
    vals = '{32'd5, -32'sd3, 32'd7, 32'd7, -32'sd10, 32'd0, 32'd1, 32'd1};
    for (int k = 0; k < 8; k++) send(0, vals[k], 1'b0);
    idle(0, 3);

    // LEN=2: hold the first result while the next pair is offered
    send(0, 32'd5, 1'b0);
    send(0, -32'sd3, 1'b0);
    out_ready[0] = 1'b0;
    fork
      begin
        send(0, 32'd7, 1'b0);
        send(0, 32'd7, 1'b0);
      end
      begin
        repeat (6) @(posedge clk);
        #1 out_ready[0] = 1'b1;
      end
    join
    idle(0, 3);

    // Reset in the middle of a LEN=4 group
    send(1, 32'd9, 1'b0);
    send(1, 32'd9, 1'b0);
    in_valid[1] = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 4; k++) send(1, 32'd1, 1'b0);
    idle(1, 3);

    // ACC_W=33 boundaries: +2^32 overflows, -2^32 fits exactly, -2^33 overflows
    send4(2, 32'h4000_0000);
    send4(2, 32'hC000_0000);
    send4(2, 32'h8000_0000);
    send4(2, 32'h7FFF_FFFF);

    // LEN=1: every accept completes a group, including while draining the previous one
    send(3, 32'd17, 1'b0);
    send(3, 32'h8000_0000, 1'b0);
    send(3, 32'h7FFF_FFFF, 1'b0);
    send(3, -32'sd1, 1'b0);
    idle(3, 3);

    // Randomized products, instance selection and output backpressure
    prev = 0;
    for (int n = 0; n < 400; n++) begin
      i = $urandom_range(0, NI-1);
      if (i != prev) in_valid[prev] = 1'b0;
      prev = i;
      case ($urandom_range(0, 2))
        0:       p = $urandom;
        1:       p = 32'($urandom_range(0, 200)) - 32'd100;
        default: p = ($urandom_range(0, 1) != 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
      endcase
      send(i, p, 1'b1);
      if ($urandom_range(0, 7) == 0) idle(i, $urandom_range(1, 3));
    end

    for (int k = 0; k < NI; k++) begin
      in_valid[k]  = 1'b0;
      out_ready[k] = 1'b1;
    end
    repeat (10) @(posedge clk);
    #1 done = 1'b1;
  end

endmodule
